sequence_detector_moore: RTL and testbench

- Serial bit-stream pattern detector, built as a Moore FSM; default pattern is 1101.
- Samples `in` on each rising clock edge and tracks how many leading pattern bits are currently matched.
- `out` is a function of state only. It asserts for one cycle per completed match.
- Sits after a serial data source as a simple frame/marker detector; overlapping matches are allowed by default.

---
 rtl/sequence_detector_moore_if.sv | 23 ++
 rtl/sequence_detector_moore.sv | 97 +++++++++
 tb/tb_sequence_detector_moore.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sequence_detector_moore_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sequence_detector_moore_if                                    |
// | Brief    : Serial bit / match-flag bundle for the Moore pattern detector.|
// |            det_count exists only when SEQ_DET_COUNT_EN is defined.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface sequence_detector_moore_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in;
  logic             out;
`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] det_count;

  modport master (output in, input  out, input  det_count);
  modport slave  (input  in, output out, output det_count);
`else
  modport master (output in, input  out);
  modport slave  (input  in, output out);
`endif
endinterface : sequence_detector_moore_if
`default_nettype wire

// File: rtl/sequence_detector_moore.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sequence_detector_moore                                       |
// | Brief    : Moore FSM serial pattern detector; SEQ_DET_COUNT_EN adds a    |
// |            saturating detection counter.                                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sequence_detector_moore #(
  parameter int unsigned          PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int unsigned          CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  sequence_detector_moore_if.slave bus
);

  localparam int unsigned c_state_w = $clog2(PATTERN_W + 1);
  localparam int unsigned c_num_enc = 2 ** c_state_w;

  typedef logic [c_state_w-1:0] state_t;

  localparam state_t S0     = '0;
  localparam state_t S_FULL = state_t'(PATTERN_W);

  // Longest pattern prefix that is a suffix of (first k pattern bits, b).
  function automatic int unsigned calc_next(input int unsigned k, input bit b);
    int unsigned k_eff;
    int unsigned seq;
    int unsigned j_max;
    int unsigned mask;
    k_eff     = (k == PATTERN_W && !OVERLAP) ? 0 : k;
    seq       = ((32'(PATTERN) >> (PATTERN_W - k_eff)) << 1) | 32'(b);
    j_max     = (k_eff + 1 > PATTERN_W) ? PATTERN_W : k_eff + 1;
    calc_next = 0;
    for (int unsigned j = 1; j <= j_max; j++) begin
      mask = (32'd1 << j) - 32'd1;
      if ((seq & mask) == (32'(PATTERN) >> (PATTERN_W - j)))
        calc_next = j;
    end
  endfunction

  generate
    if (PATTERN_W < 1 || PATTERN_W > 16 || CNT_W < 1) begin : g_param_check
      $error("sequence_detector_moore: PATTERN_W must be 1..16 and CNT_W >= 1");
    end
  endgenerate

  state_t w_next_tab [c_num_enc][2];
  state_t w_next;
  state_t r_state;
  logic   r_out;

  generate
    for (genvar gk = 0; gk < c_num_enc; gk++) begin : g_enc
      if (gk <= PATTERN_W) begin : g_valid
        assign w_next_tab[gk][0] = state_t'(calc_next(gk, 1'b0));
        assign w_next_tab[gk][1] = state_t'(calc_next(gk, 1'b1));
      end else begin : g_unreach
        // Illegal encodings fall back to the idle state on the next edge.
        assign w_next_tab[gk][0] = S0;
        assign w_next_tab[gk][1] = S0;
      end
    end
  endgenerate

  assign w_next = w_next_tab[r_state][bus.in];

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] r_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S0;
      r_out   <= 1'b0;
`ifdef SEQ_DET_COUNT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_out   <= (w_next == S_FULL);
`ifdef SEQ_DET_COUNT_EN
      if (w_next == S_FULL && r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);
`endif
    end
  end

  assign bus.out = r_out;
`ifdef SEQ_DET_COUNT_EN
  assign bus.det_count = r_cnt;
`endif

endmodule : sequence_detector_moore
`default_nettype wire

// File: tb/tb_sequence_detector_moore.sv
`default_nettype none
// Directed bench: DUT a uses OVERLAP=1, DUT b uses OVERLAP=0, both fed the same bits.
module tb_sequence_detector_moore;

`ifdef SEQ_DET_COUNT_EN
  localparam int unsigned C_CNT_W = 2;
`else
  localparam int unsigned C_CNT_W = 8;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sequence_detector_moore_if #(.CNT_W(C_CNT_W)) bif_a ();
  sequence_detector_moore_if #(.CNT_W(C_CNT_W)) bif_b ();

  sequence_detector_moore #(
    .PATTERN_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(C_CNT_W)
  ) u_dut_a (
    .clk(clk), .reset(reset), .bus(bif_a)
  );

  sequence_detector_moore #(
    .PATTERN_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(C_CNT_W)
  ) u_dut_b (
    .clk(clk), .reset(reset), .bus(bif_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic b, input logic rst_n);
    bif_a.in = b;
    bif_b.in = b;
    reset    = rst_n;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

`ifdef SEQ_DET_COUNT_EN
  task automatic chk_cnt(input string tag, input logic [C_CNT_W-1:0] obs,
                         input logic [C_CNT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
`endif

  // Feed n bits MSB first and check both outputs after every edge.
  task automatic feed(input string tag, input logic [15:0] bits, input int n,
                      input logic [15:0] exp_a, input logic [15:0] exp_b);
    for (int i = n - 1; i >= 0; i--) begin
      tick(bits[i], 1'b1);
      chk({tag, "_out_a"}, bif_a.out, exp_a[i]);
      chk({tag, "_out_b"}, bif_b.out, exp_b[i]);
    end
  endtask

  task automatic do_reset(input string tag);
    tick(1'b1, 1'b0);
    chk({tag, "_rst_a"}, bif_a.out, 1'b0);
    chk({tag, "_rst_b"}, bif_b.out, 1'b0);
`ifdef SEQ_DET_COUNT_EN
    chk_cnt({tag, "_rst_cnt_a"}, bif_a.det_count, '0);
    chk_cnt({tag, "_rst_cnt_b"}, bif_b.det_count, '0);
`endif
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    bif_a.in = 1'b1;
    bif_b.in = 1'b1;

    // Reset held two cycles with in=1.
    do_reset("hold0");
    do_reset("hold1");

    // Single match 1101 then 0.
    feed("single", 16'b11010, 5, 16'b00010, 16'b00010);
`ifdef SEQ_DET_COUNT_EN
    chk_cnt("single_cnt_a", bif_a.det_count, 2'd1);
    chk_cnt("single_cnt_b", bif_b.det_count, 2'd1);
`endif

    // Back-to-back 1101101: overlap gives two pulses, non-overlap one.
    do_reset("ovl");
    feed("ovl", 16'b11011010, 8, 16'b00010010, 16'b00010000);
`ifdef SEQ_DET_COUNT_EN
    chk_cnt("ovl_cnt_a", bif_a.det_count, 2'd2);
    chk_cnt("ovl_cnt_b", bif_b.det_count, 2'd1);
`endif

    // Run of ones then 1010 tail: only the 1101 ending at bit 7 hits.
    do_reset("nofalse");
    feed("nofalse", 16'b1111101010, 10, 16'b0000001000, 16'b0000001000);

    // Partial match 110 discarded by a mid-stream reset.
    do_reset("mid");
    feed("mid_pre", 16'b110, 3, 16'b000, 16'b000);
    do_reset("mid");
    feed("mid_post", 16'b111010, 6, 16'b000010, 16'b000010);

    // Five consecutive 1101 groups; counter saturates when narrow.
    do_reset("sat");
    for (int g = 0; g < 5; g++) begin
      feed("sat", 16'b1101, 4, 16'b0001, 16'b0001);
`ifdef SEQ_DET_COUNT_EN
      chk_cnt("sat_cnt_a", bif_a.det_count, (g >= 2) ? 2'd3 : 2'(g + 1));
      chk_cnt("sat_cnt_b", bif_b.det_count, (g >= 2) ? 2'd3 : 2'(g + 1));
`endif
    end
    feed("sat_tail", 16'b0, 1, 16'b0, 16'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sequence_detector_moore
`default_nettype wire
